arp_vlg_rx: RTL and testbench

- Receive-side ARP parser, directly downstream of the MAC RX stage.
- Consumes the Ethernet payload byte stream of frames whose ethertype is 0x0806.
- Assembles the 28-byte ARP header into the packed ARP header format (224 bits, network order) and validates it.
- Presents it, with a single-cycle strobe, to the ARP table/reply logic.

---
 rtl/arp_vlg_rx_if.sv | 16 +
 rtl/arp_vlg_rx.sv | 157 +++++++++++++++
 tb/tb_arp_vlg_rx.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/arp_vlg_rx_if.sv
// arp_vlg_rx_if: payload byte stream from the MAC RX stage into the ARP parser.
`default_nettype none

interface arp_vlg_rx_if;
  logic        rx_v;
  logic [7:0]  rx_d;
  logic        rx_sof;
  logic        rx_eof;
  logic        rx_err;
  logic [15:0] rx_ethertype;

  modport master (output rx_v, rx_d, rx_sof, rx_eof, rx_err, rx_ethertype);
  modport slave  (input  rx_v, rx_d, rx_sof, rx_eof, rx_err, rx_ethertype);
endinterface

`default_nettype wire

// File: rtl/arp_vlg_rx.sv
// arp_vlg_rx: assembles and validates the 28-byte ARP header of 0x0806 frames.
// Optional macro ARP_VLG_RX_IP_FILTER_EN: also require dst_ipv4_addr == local_ipv4.
`default_nettype none

module arp_vlg_rx #(
  parameter int TIMEOUT    = 64,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  arp_vlg_rx_if.slave           rx,
  input  logic [31:0]           local_ipv4,
  output logic [223:0]          hdr,
  output logic                  hdr_v,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, HDR, PAD, CHECK} state_t;

  state_t                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [223:0]          asm_q, asm_d;
  logic [223:0]          hdr_q, hdr_d;
  logic                  hdr_v_q, hdr_v_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic [IDLE_W-1:0]     idle_q, idle_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic drop;
  logic start;
  logic fmt_ok;
  logic ip_ok;

  assign start  = rx.rx_v & rx.rx_sof & (rx.rx_ethertype == 16'h0806);
  assign fmt_ok = ~err_q
                & (asm_q[223:208] == 16'h0001)
                & (asm_q[207:192] == 16'h0800)
                & (asm_q[191:184] == 8'd6)
                & (asm_q[183:176] == 8'd4)
                & ((asm_q[175:160] == 16'd1) | (asm_q[175:160] == 16'd2));

`ifdef ARP_VLG_RX_IP_FILTER_EN
  assign ip_ok = (asm_q[31:0] == local_ipv4);
`else
  logic unused_local_ipv4;
  assign unused_local_ipv4 = ^local_ipv4;
  assign ip_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    hdr_d   = hdr_q;
    hdr_v_d = 1'b0;
    err_d   = err_q;
    idle_d  = idle_q;
    drop    = 1'b0;

    case (state_q)
      HDR, PAD: begin
        if (rx.rx_v) begin
          idle_d = '0;
          if (rx.rx_sof) begin
            // A new frame aborts this one; a matching ethertype restarts below.
            drop    = 1'b1;
            state_d = IDLE;
          end else begin
            if (rx.rx_eof) err_d = err_q | rx.rx_err;
            if (state_q == HDR) begin
              asm_d = {asm_q[215:0], rx.rx_d};
              if (cnt_q == 5'd27) begin
                state_d = rx.rx_eof ? CHECK : PAD;
              end else if (rx.rx_eof) begin
                drop    = 1'b1;
                state_d = IDLE;
              end else begin
                cnt_d = cnt_q + 5'd1;
              end
            end else if (rx.rx_eof) begin
              state_d = CHECK;
            end
          end
        end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
          drop    = 1'b1;
          state_d = IDLE;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (!fmt_ok) begin
          drop = 1'b1;
        end else if (ip_ok) begin
          hdr_d   = asm_q;
          hdr_v_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (start && (state_q != CHECK)) begin
      asm_d  = {asm_q[215:0], rx.rx_d};
      cnt_d  = 5'd1;
      err_d  = rx.rx_eof & rx.rx_err;
      idle_d = '0;
      if (rx.rx_eof) begin
        drop    = 1'b1;
        state_d = IDLE;
      end else begin
        state_d = HDR;
      end
    end

    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != {DROP_CNT_W{1'b1}})) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      asm_q      <= '0;
      hdr_q      <= '0;
      hdr_v_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      idle_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      hdr_q      <= hdr_d;
      hdr_v_q    <= hdr_v_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      idle_q     <= idle_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign hdr      = hdr_q;
  assign hdr_v    = hdr_v_q;
  assign busy     = busy_q;
  assign drop_cnt = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_arp_vlg_rx.sv
// tb_arp_vlg_rx: directed and randomized frames checked against a frame-level ARP model.
`default_nettype none

module tb_arp_vlg_rx;

  localparam int TIMEOUT = 64;
  localparam int DW      = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   local_ipv4 = 32'hC0A80102;
  logic [223:0]  hdr;
  logic          hdr_v;
  logic          busy;
  logic [DW-1:0] drop_cnt;

  arp_vlg_rx_if rx_if ();

  arp_vlg_rx #(.TIMEOUT(TIMEOUT), .DROP_CNT_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx_if.slave),
    .local_ipv4 (local_ipv4),
    .hdr        (hdr),
    .hdr_v      (hdr_v),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           pulses = 0;
  int           exp_acc = 0;
  logic [223:0] exp_hdr = '0;
  int           exp_drop = 0;
  logic [7:0]   fb[$];

  always @(negedge clk) if (hdr_v === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [223:0] obs, input logic [223:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    rx_if.rx_v         = 1'b0;
    rx_if.rx_d         = 8'($urandom);
    rx_if.rx_sof       = 1'($urandom);
    rx_if.rx_eof       = 1'($urandom);
    rx_if.rx_err       = 1'($urandom);
    rx_if.rx_ethertype = 16'($urandom);
  endtask

  task automatic build_frame(input logic [15:0] hw, input logic [15:0] proto, input logic [7:0] hlen,
                             input logic [7:0] plen, input logic [15:0] oper, input logic [31:0] dip,
                             input int len, input bit rnd);
    logic [47:0] smac;
    logic [31:0] sip;
    smac = rnd ? {16'($urandom), $urandom} : 48'h020000000001;
    sip  = rnd ? $urandom : 32'hC0A8010A;
    fb.delete();
    fb.push_back(hw[15:8]);    fb.push_back(hw[7:0]);
    fb.push_back(proto[15:8]); fb.push_back(proto[7:0]);
    fb.push_back(hlen);        fb.push_back(plen);
    fb.push_back(oper[15:8]);  fb.push_back(oper[7:0]);
    for (int i = 5; i >= 0; i--) fb.push_back(smac[8*i +: 8]);
    for (int i = 3; i >= 0; i--) fb.push_back(sip[8*i +: 8]);
    for (int i = 0; i < 6; i++)  fb.push_back(8'h00);
    for (int i = 3; i >= 0; i--) fb.push_back(dip[8*i +: 8]);
    while (fb.size() > len) void'(fb.pop_back());
    while (fb.size() < len) fb.push_back(8'($urandom));
  endtask

  task automatic send_bytes(input logic [15:0] et, input logic [7:0] b[$], input bit eof_last,
                            input bit err, input int maxgap);
    for (int i = 0; i < b.size(); i++) begin
      repeat ($urandom_range(0, maxgap)) begin
        @(negedge clk);
        idle_inputs();
      end
      @(negedge clk);
      rx_if.rx_v         = 1'b1;
      rx_if.rx_d         = b[i];
      rx_if.rx_sof       = (i == 0);
      rx_if.rx_eof       = eof_last && (i == b.size() - 1);
      rx_if.rx_err       = (i == b.size() - 1) ? err : 1'($urandom);
      rx_if.rx_ethertype = (i == 0) ? et : 16'($urandom);
    end
  endtask

  // Frame-level model: decide the outcome from the bytes, then check the strobe window.
  task automatic send_frame(input string tag, input logic [15:0] et, input logic [7:0] b[$],
                            input bit err, input int maxgap);
    bit           is_arp, full, fmt, ipok;
    logic [223:0] h;
    h      = '0;
    is_arp = (et == 16'h0806);
    full   = (b.size() >= 28);
    fmt    = 1'b0;
    ipok   = 1'b1;
    if (is_arp && full) begin
      for (int n = 0; n < 28; n++) h[223 - 8*n -: 8] = b[n];
      fmt = !err && h[223:208] == 16'h0001 && h[207:192] == 16'h0800 && h[191:184] == 8'd6
            && h[183:176] == 8'd4 && (h[175:160] == 16'd1 || h[175:160] == 16'd2);
`ifdef ARP_VLG_RX_IP_FILTER_EN
      ipok = (h[31:0] == local_ipv4);
`endif
    end
    send_bytes(et, b, 1'b1, err, maxgap);
    @(negedge clk);
    idle_inputs();
    chk({tag, ".busy_check"}, {223'd0, busy}, {223'd0, is_arp && full});
    chk({tag, ".hdr_v_early"}, {223'd0, hdr_v}, '0);
    @(negedge clk);
    if (is_arp && !fmt && exp_drop != 65535) exp_drop++;
    if (fmt && ipok) begin
      exp_hdr = h;
      exp_acc++;
    end
    chk({tag, ".hdr_v"}, {223'd0, hdr_v}, {223'd0, fmt && ipok});
    chk({tag, ".hdr"}, hdr, exp_hdr);
    chk({tag, ".drop_cnt"}, {208'd0, drop_cnt}, 224'(exp_drop));
    chk({tag, ".busy_after"}, {223'd0, busy}, '0);
    @(negedge clk);
    chk({tag, ".hdr_v_late"}, {223'd0, hdr_v}, '0);
  endtask

  initial begin
    logic [31:0] dip;
    int          kind, len;
    logic [15:0] oper;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("reset.hdr", hdr, '0);
    chk("reset.hdr_v", {223'd0, hdr_v}, '0);
    chk("reset.busy", {223'd0, busy}, '0);
    chk("reset.drop_cnt", {208'd0, drop_cnt}, '0);
    rst = 1'b0;

    build_frame(16'h1, 16'h0800, 8'd6, 8'd4, 16'd1, 32'hC0A80101, 28, 1'b0);
    send_frame("request", 16'h0806, fb, 1'b0, 0);
`ifndef ARP_VLG_RX_IP_FILTER_EN
    chk("request.hw_type", {208'd0, hdr[223:208]}, 224'h0001);
    chk("request.dst_ip", {192'd0, hdr[31:0]}, 224'hC0A80101);
`endif
    build_frame(16'h1, 16'h0800, 8'd6, 8'd4, 16'd2, 32'hC0A80102, 46, 1'b0);
    send_frame("padded", 16'h0806, fb, 1'b0, 2);
    build_frame(16'h1, 16'h0800, 8'd6, 8'd4, 16'd1, 32'hC0A80102, 20, 1'b0);
    send_frame("short20", 16'h0806, fb, 1'b0, 1);
    build_frame(16'h1, 16'h0800, 8'd8, 8'd4, 16'd1, 32'hC0A80102, 28, 1'b0);
    send_frame("hlen8", 16'h0806, fb, 1'b0, 1);
    build_frame(16'h1, 16'h0800, 8'd6, 8'd4, 16'd3, 32'hC0A80102, 28, 1'b0);
    send_frame("oper3", 16'h0806, fb, 1'b0, 1);
    build_frame(16'h1, 16'h0800, 8'd6, 8'd4, 16'd1, 32'hC0A80102, 28, 1'b0);
    send_frame("rx_err", 16'h0806, fb, 1'b1, 1);
    send_frame("ipv4_type", 16'h0800, fb, 1'b0, 1);

    // Stall after byte 10: busy holds for TIMEOUT-1 idle cycles, drops on the TIMEOUT-th.
    build_frame(16'h1, 16'h0800, 8'd6, 8'd4, 16'd1, 32'hC0A80102, 11, 1'b0);
    send_bytes(16'h0806, fb, 1'b0, 1'b0, 0);
    repeat (TIMEOUT) begin
      @(negedge clk);
      idle_inputs();
    end
    chk("timeout.busy_before", {223'd0, busy}, 224'd1);
    @(negedge clk);
    exp_drop++;
    chk("timeout.busy_after", {223'd0, busy}, '0);
    chk("timeout.drop_cnt", {208'd0, drop_cnt}, 224'(exp_drop));
    build_frame(16'h1, 16'h0800, 8'd6, 8'd4, 16'd1, 32'hC0A80102, 28, 1'b1);
    send_frame("after_timeout", 16'h0806, fb, 1'b0, 3);

    build_frame(16'h1, 16'h0800, 8'd6, 8'd4, 16'd1, 32'hC0A80102, 15, 1'b1);
    send_bytes(16'h0806, fb, 1'b0, 1'b0, 1);
    exp_drop++;
    build_frame(16'h1, 16'h0800, 8'd6, 8'd4, 16'd2, 32'hC0A80102, 30, 1'b1);
    send_frame("restart", 16'h0806, fb, 1'b0, 1);

    for (int f = 0; f < 120; f++) begin
      kind = $urandom_range(0, 7);
      dip  = $urandom_range(0, 1) ? 32'hC0A80102 : 32'hC0A80101;
      len  = $urandom_range(0, 1) ? 28 : $urandom_range(29, 60);
      oper = 16'($urandom_range(1, 2));
      case (kind)
        3: build_frame(16'h1, 16'h0800, 8'($urandom_range(0, 5)), 8'd4, oper, dip, len, 1'b1);
        4: build_frame(16'h1, 16'h0800, 8'd6, 8'd4, $urandom_range(0, 1) ? 16'd0 : 16'($urandom_range(3, 65535)), dip, len, 1'b1);
        5: build_frame(16'($urandom_range(2, 9)), 16'h0800, 8'd6, 8'd4, oper, dip, len, 1'b1);
        6: build_frame(16'h1, 16'h0800, 8'd6, 8'd4, oper, dip, $urandom_range(1, 27), 1'b1);
        default: build_frame(16'h1, 16'h0800, 8'd6, 8'd4, oper, dip, len, 1'b1);
      endcase
      send_frame("random", (kind == 7) ? 16'h86DD : 16'h0806, fb, (kind == 2) && $urandom_range(0, 1) == 1, 3);
    end

    // Asynchronous reset mid-frame: no strobe, no count, all outputs cleared.
    build_frame(16'h1, 16'h0800, 8'd6, 8'd4, 16'd1, 32'hC0A80102, 10, 1'b1);
    send_bytes(16'h0806, fb, 1'b0, 1'b0, 0);
    #2 rst = 1'b1;
    @(negedge clk);
    idle_inputs();
    exp_hdr  = '0;
    exp_drop = 0;
    chk("midreset.busy", {223'd0, busy}, '0);
    chk("midreset.hdr", hdr, '0);
    chk("midreset.drop_cnt", {208'd0, drop_cnt}, '0);
    rst = 1'b0;
    build_frame(16'h1, 16'h0800, 8'd6, 8'd4, 16'd1, 32'hC0A80102, 28, 1'b1);
    send_frame("post_reset", 16'h0806, fb, 1'b0, 1);

    chk("total_pulses", 224'(pulses), 224'(exp_acc));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
